tt_capture_driver: RTL and testbench

//  Stimulus/response end of a generated combinational netlist: drives every input pattern of the

---
 rtl/tt_capture_driver.sv | 167 ++++++++++++++++
 tb/tb_tt_capture_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_capture_driver.sv
// ----------------------------------------------------------------------------
// tt_capture_driver
//
// Drives every input pattern of a combinational netlist in ascending order,
// samples the netlist outputs for each pattern, and packs the responses into
// a truth table. The captured table is compared against a golden table that
// is latched when the run is accepted. The lowest failing pattern is reported.
//
// Parameters
//   N_PI    number of netlist primary inputs (patterns = 2**N_PI)
//   N_PO    number of netlist primary outputs
//   SETTLE  cycles a pattern is held before its response is sampled (>= 0)
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   run request, accepted only while idle
//   expected  in   golden table, latched on an accepted start
//   busy      out  high from the cycle after accept until done
//   done      out  one-cycle pulse after the last pattern is sampled
//   pi_out    out  pattern driven to the netlist (bit0 = pi0)
//   po_in     in   netlist outputs po0..po(N_PO-1)
//   tt_out    out  captured table, bit j*2**N_PI+p = po_j under pattern p
//   mismatch  out  sticky: some captured bit differs from expected
//   fail_idx  out  pattern index of the first mismatch (0 if none)
// ----------------------------------------------------------------------------
module tt_capture_driver #(
    parameter int N_PI   = 5,
    parameter int N_PO   = 1,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_PO*(2**N_PI)-1:0]    expected,
    output logic                         busy,
    output logic                         done,
    output logic [N_PI-1:0]              pi_out,
    input  logic [N_PO-1:0]              po_in,
    output logic [N_PO*(2**N_PI)-1:0]    tt_out,
    output logic                         mismatch,
    output logic [N_PI-1:0]              fail_idx
);

    localparam int unsigned NPAT = 2 ** N_PI;
    localparam int unsigned NPO  = N_PO;
    localparam int unsigned TW   = NPO * NPAT;
    localparam int          IW   = (TW > 1) ? $clog2(TW) : 1;
    localparam int          CW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    // The counter holds the settle cycles still to go after the current one,
    // so the settle state lasts exactly SETTLE cycles before sampling.
    localparam logic [CW-1:0] RELOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_ST,
        SAMPLE,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_PI-1:0]   pi_q, pi_d;
    logic [TW-1:0]     tt_q, tt_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic              mm_q, mm_d;
    logic [N_PI-1:0]   fidx_q, fidx_d;
    logic              hit;
    logic [IW-1:0]     idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pi_q    <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            mm_q    <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            mm_q    <= mm_d;
            fidx_q  <= fidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        mm_d    = mm_q;
        fidx_d  = fidx_q;
        hit     = 1'b0;
        idx     = '0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    tt_d    = '0;
                    mm_d    = 1'b0;
                    fidx_d  = '0;
                    pi_d    = '0;
                    cnt_d   = RELOAD;
                    state_d = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
                end
            end

            SETTLE_ST: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SAMPLE: begin
                busy = 1'b1;
                for (int unsigned j = 0; j < NPO; j++) begin
                    idx       = IW'(j * NPAT) + IW'(pi_q);
                    tt_d[idx] = po_in[j];
                    if (po_in[j] != exp_q[idx]) begin
                        hit = 1'b1;
                    end
                end
                // Only the first failing pattern is recorded; later ones
                // leave fail_idx untouched.
                if (hit && !mm_q) begin
                    mm_d   = 1'b1;
                    fidx_d = pi_q;
                end
                if (pi_q == '1) begin
                    state_d = FINISH;
                end else begin
                    pi_d    = pi_q + 1'b1;
                    cnt_d   = RELOAD;
                    state_d = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pi_out   = pi_q;
    assign tt_out   = tt_q;
    assign mismatch = mm_q;
    assign fail_idx = fidx_q;

endmodule

// File: tb/tb_tt_capture_driver.sv
module tb_tt_capture_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [31:0] exp0;
    logic [63:0] exp1;
    logic        busy0, done0, busy1, done1;
    logic [4:0]  pi0, pi1;
    logic        po0;
    logic [1:0]  po1;
    logic [31:0] tt0;
    logic [63:0] tt1;
    logic        mm0, mm1;
    logic [4:0]  fidx0, fidx1;

    // Netlist behaviour as truth tables indexed by the driven pattern.
    logic [31:0] tbl0;
    logic [31:0] tbl1 [2];

    int unsigned cyc = 0;
    int unsigned acc0 = 0, acc1 = 0;
    bit          run0 = 0, run1 = 0;
    int          total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    tt_capture_driver #(.N_PI(5), .N_PO(1), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(exp0),
        .busy(busy0), .done(done0), .pi_out(pi0), .po_in(po0),
        .tt_out(tt0), .mismatch(mm0), .fail_idx(fidx0)
    );

    tt_capture_driver #(.N_PI(5), .N_PO(2), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1),
        .busy(busy1), .done(done1), .pi_out(pi1), .po_in(po1),
        .tt_out(tt1), .mismatch(mm1), .fail_idx(fidx1)
    );

    // With SETTLE=1 the response is taken on even cycles 2..64 after accept;
    // at every other cycle the netlist output is inverted so that sampling at
    // the wrong moment corrupts the captured table.
    int unsigned off0;
    always_comb begin
        off0 = cyc - acc0;
        po0  = tbl0[pi0] ^ !(run0 && off0 >= 2 && off0 <= 64 && off0[0] == 1'b0);
    end
    assign po1 = {tbl1[1][pi1], tbl1[0][pi1]};

    typedef struct {
        logic [63:0] tt;
        logic        mm;
        logic [4:0]  fidx;
        int unsigned due;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1;

    // Reference: the captured table is just the netlist table; mismatch is any
    // difference; the failing index is the lowest pattern with any differing output.
    function automatic exp_t model(input logic [63:0] tbl, input logic [63:0] ex,
                                   input int n_po, input int unsigned due);
        exp_t r;
        bit   found = 0;
        r.tt   = tbl;
        r.mm   = (tbl != ex);
        r.fidx = '0;
        r.due  = due;
        for (int p = 0; p < 32; p++)
            for (int j = 0; j < n_po; j++)
                if (!found && tbl[j*32+p] != ex[j*32+p]) begin
                    r.fidx = 5'(p);
                    found  = 1;
                end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor for dut0
    always @(negedge clk) begin
        if (!rst && done0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL spurious_done0: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("done_cycle0", 64'(cyc), 64'(e0.due));
                chk("tt0", {32'h0, tt0}, e0.tt);
                chk("mismatch0", 64'(mm0), 64'(e0.mm));
                chk("fail_idx0", 64'(fidx0), 64'(e0.fidx));
                chk("busy_at_done0", 64'(busy0), 64'd0);
                run0 = 0;
            end
        end
    end

    // Monitor for dut1, including the one-pattern-per-cycle stepping
    always @(negedge clk) begin
        if (!rst && run1 && busy1)
            chk("pi_step1", 64'(pi1), 64'(cyc - acc1 - 1));
        if (!rst && done1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL spurious_done1: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("done_cycle1", 64'(cyc), 64'(e1.due));
                chk("tt1", tt1, e1.tt);
                chk("mismatch1", 64'(mm1), 64'(e1.mm));
                chk("fail_idx1", 64'(fidx1), 64'(e1.fidx));
                run1 = 0;
            end
        end
    end

    task automatic go0(input logic [31:0] t, input logic [31:0] ex);
        @(negedge clk);
        tbl0   = t;
        exp0   = ex;
        start0 = 1'b1;
        acc0   = cyc;
        run0   = 1;
        q0.push_back(model({32'h0, t}, {32'h0, ex}, 1, cyc + 65));
        @(negedge clk);
        start0 = 1'b0;
        exp0   = $urandom;
    endtask

    task automatic go1(input logic [31:0] t0, input logic [31:0] t1, input logic [63:0] ex);
        @(negedge clk);
        tbl1[0] = t0;
        tbl1[1] = t1;
        exp1    = ex;
        start1  = 1'b1;
        acc1    = cyc;
        run1    = 1;
        q1.push_back(model({t1, t0}, ex, 2, cyc + 33));
        @(negedge clk);
        start1 = 1'b0;
        exp1   = {$urandom, $urandom};
    endtask

    task automatic wait0();
        for (int i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL timeout0: got pending=%0d want 0", q0.size());
            q0.delete();
            run0 = 0;
        end
    endtask

    task automatic wait1();
        for (int i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL timeout1: got pending=%0d want 0", q1.size());
            q1.delete();
            run1 = 0;
        end
    endtask

    function automatic logic [31:0] flip(input logic [31:0] t);
        case ($urandom_range(0, 2))
            0:       return t;
            1:       return t ^ (32'h1 << $urandom_range(0, 31));
            default: return t ^ $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] t, u;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        exp0 = '0; exp1 = '0; tbl0 = '0; tbl1[0] = '0; tbl1[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_pi0", 64'(pi0), 64'd0);
        chk("rst_tt0", 64'(tt0), 64'd0);
        chk("rst_mm0", 64'(mm0), 64'd0);
        chk("rst_fidx0", 64'(fidx0), 64'd0);
        chk("rst_tt1", tt1, 64'd0);
        rst = 1'b0;

        // Directed cases
        go0(32'h0000_000E, 32'h0000_000E); wait0();
        go0(32'h0000_000E, 32'h0000_000F); wait0();
        go0(32'hFFFF_FFFF, 32'hFFFF_FF7F); wait0();

        // Restart attempt mid-run must be ignored
        go0(32'h0000_000E, 32'h0000_000E);
        repeat (8) @(negedge clk);
        start0 = 1'b1; exp0 = 32'hDEAD_BEEF;
        @(negedge clk);
        start0 = 1'b0;
        wait0();
        repeat (80) @(negedge clk);

        // Reset mid-run aborts with no done pulse
        go0(32'hFFFF_FFFF, 32'h1234_5678);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        q0.delete();
        run0 = 0;
        chk("abort_busy0", 64'(busy0), 64'd0);
        chk("abort_pi0", 64'(pi0), 64'd0);
        chk("abort_tt0", 64'(tt0), 64'd0);
        chk("abort_mm0", 64'(mm0), 64'd0);
        chk("abort_done0", 64'(done0), 64'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        go0(32'h0000_000E, 32'h0000_000E); wait0();

        // Two outputs, no settle
        go1(32'h6666_6666, 32'hFFFF_0000, {32'hFFFF_0000, 32'h6666_6666}); wait1();

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            t = $urandom;
            go0(t, flip(t)); wait0();
            t = $urandom; u = $urandom;
            go1(t, u, {flip(u), flip(t)}); wait1();
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
